iosys_sdram_arbiter: RTL and testbench
======================================

// Module: iosys_sdram_arbiter
// PURPOSE
// - Owns the iosys 16-bit SDRAM port; shares it between the flash firmware loader (16-bit writes)
//   and the picorv32 memory bus (32-bit words), split into two 16-bit halves.
// - Issues commands only in clkref==0 slots and retries on sd_wait. Sits between iosys bus decode
//   and the top-level SDRAM controller port.
// PARAMETERS
// - RAM_LIMIT  32'h0080_0000  CPU addresses >= this are ignored (left to other decoders)
// PORTS
// - clk        in   1   SNES mclk, only clock
// - reset      in   1   synchronous, active-high
// - clkref     in   1   mclk/2 phase; a "slot" is a clk edge where clkref==0
// - ram_busy   in   1   SDRAM initialising; no grants while high
// - fl_req     in   1   flash loader write request, held until fl_ack
// - fl_addr    in   23  byte address (bit0 ignored)
// - fl_wdata   in   16  write data, ds=2'b11
// - fl_ack     out  1   1-cycle pulse: flash write accepted by SDRAM
// - cpu_valid  in   1   picorv32 mem_valid
// - cpu_addr   in   32  byte address, word aligned
// - cpu_wdata  in   32  write data
// - cpu_wstrb  in   4   byte strobes; 0 = read
// - cpu_ready  out  1   1-cycle pulse completing the CPU transfer
// - cpu_rdata  out  32  read data, valid while cpu_ready==1
// - sd_addr    out  23  SDRAM byte address
// - sd_din     out  16  SDRAM write data
// - sd_ds      out  2   byte enables {hi,lo}
// - sd_rd      out  1   read request level
// - sd_wr      out  1   write request level
// - sd_dout    in   16  SDRAM read data
// - sd_wait    in   1   SDRAM not ready; hold current request
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE; reset mid-transfer aborts, sd_rd/sd_wr low next cycle.
// - State advances only in slots; outside slots every register holds. fl_ack/cpu_ready are
//   cleared every cycle unless set.
// - IDLE slot: ~ram_busy & fl_req -> FL (flash wins, fixed priority, no preemption mid-transfer).
//   Else: ~ram_busy & cpu_valid & cpu_addr<RAM_LIMIT & ~cpu_ready_q -> CPU_LO.
//   cpu_ready_q = cpu_ready of the previous cycle; it blocks a re-grant of the same request.
// - FL: sd_addr={fl_addr[22:1],0}, sd_din=fl_wdata, sd_ds=11, sd_wr=1 held >=2 cycles.
//   Next slot with ~sd_wait: sd_wr=0, fl_ack=1, -> IDLE.
// - CPU_LO, on entry:
//   - sd_addr={cpu_addr[22:2],00}.
//   - Write: sd_din=wdata[15:0], sd_ds=wstrb[1:0]; latch hi half; cpu_ready=1 (posted write).
//     If wstrb[1:0]==00 the lo half is skipped and the hi half is issued in this slot.
//   - Read: sd_rd=1, sd_ds=11.
// - CPU_HI slot with ~sd_wait:
//   - sd_addr low bits=10; issue hi half; write uses latched data/strobes.
//   - Write with latched hi strobes==00: no hi cycle; drop sd_wr and -> IDLE.
// - CPU_END slot with ~sd_wait:
//   - Write: sd_wr=0, -> IDLE.
//   - Read: cpu_rdata[15:0]=sd_dout, sd_rd=0, -> CPU_RD2.
// - CPU_RD2 slot: cpu_rdata[31:16]=sd_dout, cpu_ready=1, -> IDLE.
//   Read latency from grant = 4 slots + sd_wait stalls.
// - sd_wait high in any state: hold all sd_* outputs unchanged and retry next slot.
// - Simultaneous fl_req and cpu_valid at IDLE: flash served first; CPU served on the next IDLE
//   slot. A flash request raised mid-CPU transfer waits for IDLE.
// - Posted write followed at once by a new request: the new request waits until IDLE.
// STRUCTURE
// - Package iosys_pkg: arb_state_t {IDLE,FL,CPU_LO,CPU_HI,CPU_END,CPU_RD2}, RAM_LIMIT default,
//   SDRAM_AW=23.
// - Single module; no sub-module (sequencer is one FSM plus hi-half latch).
// TESTING
// - Flash write 0x1234 @0x000102, sd_wait=0 -> sd_wr high 2 cycles, addr 0x000102, ds=11;
//   fl_ack 1 pulse.
// - CPU read @0x0000_0100, SDRAM returns 0xBEEF then 0xDEAD -> lo/hi addrs 0x100/0x102;
//   cpu_rdata=0xDEADBEEF, one cpu_ready pulse.
// - CPU write 0xCAFEF00D strobe 4'b1100 @0x200 -> lo half skipped; one write 0xCAFE ds=11
//   @0x202; cpu_ready at grant.
// - fl_req and cpu_valid rise in same slot -> flash completes (fl_ack) before CPU sd_rd asserts.
// - sd_wait high 5 cycles during CPU_HI -> sd_* unchanged throughout; completes after release.
// - reset asserted during CPU_RD2; cpu_addr>=0x0080_0000 -> reset: outputs 0 next cycle, no
//   cpu_ready; high address: never granted.

Source files
------------

// File: rtl/iosys_sdram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iosys_pkg
// Description : Shared types and constants for the iosys SDRAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package iosys_pkg;

    localparam int          SDRAM_AW          = 23;
    localparam logic [31:0] RAM_LIMIT_DEFAULT = 32'h0080_0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FL      = 3'd1,
        CPU_LO  = 3'd2,
        CPU_HI  = 3'd3,
        CPU_END = 3'd4,
        CPU_RD2 = 3'd5
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/iosys_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : iosys_sdram_arbiter
// Description : Shares the 16-bit SDRAM port between the flash loader and the
//               picorv32 bus; commands change only in clkref==0 slots.
// Revision    : 1.0 - initial release
// ============================================================================
module iosys_sdram_arbiter
    import iosys_pkg::*;
#(
    parameter logic [31:0] RAM_LIMIT = RAM_LIMIT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clkref,
    input  logic                ram_busy,
    input  logic                fl_req,
    input  logic [SDRAM_AW-1:0] fl_addr,
    input  logic [15:0]         fl_wdata,
    output logic                fl_ack,
    input  logic                cpu_valid,
    input  logic [31:0]         cpu_addr,
    input  logic [31:0]         cpu_wdata,
    input  logic [3:0]          cpu_wstrb,
    output logic                cpu_ready,
    output logic [31:0]         cpu_rdata,
    output logic [SDRAM_AW-1:0] sd_addr,
    output logic [15:0]         sd_din,
    output logic [1:0]          sd_ds,
    output logic                sd_rd,
    output logic                sd_wr,
    input  logic [15:0]         sd_dout,
    input  logic                sd_wait
);

    arb_state_t          state, state_n;
    logic [SDRAM_AW-1:0] addr_n;
    logic [15:0]         din_n;
    logic [1:0]          ds_n;
    logic                rd_n, wr_n;
    logic                fl_ack_n, cpu_ready_n;
    logic [31:0]         rdata_n;
    logic                cpu_ready_q;
    logic                cpu_is_wr, cpu_is_wr_n;
    logic [15:0]         hi_data, hi_data_n;
    logic [1:0]          hi_ds, hi_ds_n;

    logic slot;
    logic cpu_in_range;
    logic unused_bits;

    assign slot         = ~clkref;
    assign cpu_in_range = (cpu_addr < RAM_LIMIT);
    assign unused_bits  = fl_addr[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sd_addr     <= '0;
            sd_din      <= '0;
            sd_ds       <= '0;
            sd_rd       <= 1'b0;
            sd_wr       <= 1'b0;
            fl_ack      <= 1'b0;
            cpu_ready   <= 1'b0;
            cpu_rdata   <= '0;
            cpu_ready_q <= 1'b0;
            cpu_is_wr   <= 1'b0;
            hi_data     <= '0;
            hi_ds       <= '0;
        end else begin
            state       <= state_n;
            sd_addr     <= addr_n;
            sd_din      <= din_n;
            sd_ds       <= ds_n;
            sd_rd       <= rd_n;
            sd_wr       <= wr_n;
            fl_ack      <= fl_ack_n;
            cpu_ready   <= cpu_ready_n;
            cpu_rdata   <= rdata_n;
            cpu_ready_q <= cpu_ready;
            cpu_is_wr   <= cpu_is_wr_n;
            hi_data     <= hi_data_n;
            hi_ds       <= hi_ds_n;
        end
    end

    always_comb begin
        state_n     = state;
        addr_n      = sd_addr;
        din_n       = sd_din;
        ds_n        = sd_ds;
        rd_n        = sd_rd;
        wr_n        = sd_wr;
        fl_ack_n    = 1'b0;
        cpu_ready_n = 1'b0;
        rdata_n     = cpu_rdata;
        cpu_is_wr_n = cpu_is_wr;
        hi_data_n   = hi_data;
        hi_ds_n     = hi_ds;

        if (slot) begin
            case (state)
                IDLE: begin
                    if (!ram_busy && fl_req) begin
                        state_n = FL;
                        addr_n  = {fl_addr[SDRAM_AW-1:1], 1'b0};
                        din_n   = fl_wdata;
                        ds_n    = 2'b11;
                        wr_n    = 1'b1;
                    end else if (!ram_busy && cpu_valid && cpu_in_range && !cpu_ready_q) begin
                        state_n     = CPU_LO;
                        addr_n      = {cpu_addr[SDRAM_AW-1:2], 2'b00};
                        cpu_is_wr_n = |cpu_wstrb;
                        if (|cpu_wstrb) begin
                            // Writes are posted: the CPU is released at grant.
                            wr_n        = 1'b1;
                            cpu_ready_n = 1'b1;
                            hi_data_n   = cpu_wdata[31:16];
                            hi_ds_n     = cpu_wstrb[3:2];
                            if (cpu_wstrb[1:0] == 2'b00) begin
                                // Issue the hi half now; clearing the latched
                                // strobes makes CPU_HI finish without a second cycle.
                                addr_n[1] = 1'b1;
                                din_n     = cpu_wdata[31:16];
                                ds_n      = cpu_wstrb[3:2];
                                hi_ds_n   = 2'b00;
                            end else begin
                                din_n = cpu_wdata[15:0];
                                ds_n  = cpu_wstrb[1:0];
                            end
                        end else begin
                            rd_n = 1'b1;
                            ds_n = 2'b11;
                        end
                    end
                end
                FL: begin
                    if (!sd_wait) begin
                        wr_n     = 1'b0;
                        fl_ack_n = 1'b1;
                        state_n  = IDLE;
                    end
                end
                CPU_LO: begin
                    if (!sd_wait) state_n = CPU_HI;
                end
                CPU_HI: begin
                    if (!sd_wait) begin
                        if (cpu_is_wr && hi_ds == 2'b00) begin
                            wr_n    = 1'b0;
                            state_n = IDLE;
                        end else begin
                            addr_n[1] = 1'b1;
                            if (cpu_is_wr) begin
                                din_n = hi_data;
                                ds_n  = hi_ds;
                            end
                            state_n = CPU_END;
                        end
                    end
                end
                CPU_END: begin
                    if (!sd_wait) begin
                        if (cpu_is_wr) begin
                            wr_n    = 1'b0;
                            state_n = IDLE;
                        end else begin
                            rdata_n[15:0] = sd_dout;
                            rd_n          = 1'b0;
                            state_n       = CPU_RD2;
                        end
                    end
                end
                CPU_RD2: begin
                    if (!sd_wait) begin
                        rdata_n[31:16] = sd_dout;
                        cpu_ready_n    = 1'b1;
                        state_n        = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iosys_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_iosys_sdram_arbiter
// Description : Scoreboard bench for iosys_sdram_arbiter with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iosys_sdram_arbiter;

    localparam int K_WR = 1, K_RD = 2, K_WEND = 3, K_FLACK = 4, K_RDY = 5;

    typedef struct {
        int          kind;
        logic [22:0] addr;
        logic [31:0] data;
        logic [1:0]  ds;
        bit          chk;
    } ev_t;

    logic        clk, reset, clkref, ram_busy;
    logic        fl_req;
    logic [22:0] fl_addr;
    logic [15:0] fl_wdata;
    logic        fl_ack;
    logic        cpu_valid;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic [22:0] sd_addr;
    logic [15:0] sd_din;
    logic [1:0]  sd_ds;
    logic        sd_rd, sd_wr;
    logic [15:0] sd_dout;
    logic        sd_wait;

    int  errors = 0;
    int  checks = 0;
    ev_t exp_q[$];

    iosys_sdram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .clkref    (clkref),
        .ram_busy  (ram_busy),
        .fl_req    (fl_req),
        .fl_addr   (fl_addr),
        .fl_wdata  (fl_wdata),
        .fl_ack    (fl_ack),
        .cpu_valid (cpu_valid),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wstrb (cpu_wstrb),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .sd_addr   (sd_addr),
        .sd_din    (sd_din),
        .sd_ds     (sd_ds),
        .sd_rd     (sd_rd),
        .sd_wr     (sd_wr),
        .sd_dout   (sd_dout),
        .sd_wait   (sd_wait)
    );

    // clkref flips on the falling edge so it is stable at every rising edge.
    initial begin
        clk    = 1'b0;
        clkref = 1'b0;
        forever begin
            #5 clk = 1'b1;
            #5 begin clk = 1'b0; clkref = ~clkref; end
        end
    end

    // SDRAM model: data for the address seen at the previous slot.
    logic [22:0] last_addr = '0;
    function automatic logic [15:0] mem_rd(input logic [22:0] a);
        case (a)
            23'h000100: return 16'hBEEF;
            23'h000102: return 16'hDEAD;
            23'h000300: return 16'h1111;
            23'h000302: return 16'h2222;
            23'h000400: return 16'h5A5A;
            23'h000402: return 16'hA5A5;
            default:    return 16'h0000;
        endcase
    endfunction
    always @(posedge clk) if (!clkref) last_addr <= sd_addr;
    assign sd_dout = mem_rd(last_addr);

    function automatic ev_t mk(input int k, input logic [22:0] a, input logic [31:0] d,
                               input logic [1:0] s, input bit c);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.ds = s; e.chk = c;
        return e;
    endfunction

    task automatic score(input ev_t got);
        ev_t e;
        bit  bad;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h ds=%b, expected none",
                     got.kind, got.addr, got.data, got.ds);
            return;
        end
        e   = exp_q.pop_front();
        bad = (got.kind != e.kind);
        if (!bad) begin
            case (e.kind)
                K_WR:   bad = (got.addr != e.addr) || (got.data != e.data) || (got.ds != e.ds);
                K_RD:   bad = (got.addr != e.addr);
                K_WEND: bad = (got.data != e.data);
                K_RDY:  bad = e.chk && (got.data != e.data);
                default: bad = 1'b0;
            endcase
        end
        if (bad) begin
            errors++;
            $display("FAIL event: got kind=%0d addr=%h data=%h ds=%b, expected kind=%0d addr=%h data=%h ds=%b",
                     got.kind, got.addr, got.data, got.ds, e.kind, e.addr, e.data, e.ds);
        end
    endtask

    // Monitor: turns output activity into events and scores them in order.
    initial begin
        logic        p_wr, p_rd;
        logic [22:0] p_addr;
        logic [15:0] p_din;
        int          wr_len;
        p_wr = 0; p_rd = 0; p_addr = '0; p_din = '0; wr_len = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (sd_wr && (!p_wr || sd_addr != p_addr || sd_din != p_din))
                    score(mk(K_WR, sd_addr, {16'h0, sd_din}, sd_ds, 1'b0));
                if (sd_rd && (!p_rd || sd_addr != p_addr))
                    score(mk(K_RD, sd_addr, 32'h0, sd_ds, 1'b0));
                if (sd_wr) wr_len++;
                if (!sd_wr && p_wr) begin
                    score(mk(K_WEND, '0, wr_len, 2'b00, 1'b0));
                    wr_len = 0;
                end
                if (fl_ack)    score(mk(K_FLACK, '0, 32'h0, 2'b00, 1'b0));
                if (cpu_ready) score(mk(K_RDY, '0, cpu_rdata, 2'b00, 1'b0));
            end else begin
                wr_len = 0;
            end
            p_wr = sd_wr; p_rd = sd_rd; p_addr = sd_addr; p_din = sd_din;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    // Leaves the bench just before a slot edge.
    task automatic to_slot();
        cyc(1);
        if (clkref) cyc(1);
    endtask

    task automatic wait_sig(input int which, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            cyc(1);
            case (which)
                0: seen = fl_ack;
                1: seen = cpu_ready;
                2: seen = sd_rd;
                default: seen = sd_wr;
            endcase
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: got no pulse in 60 cycles, expected a pulse", nm);
        end
    endtask

    initial begin
        int n;
        reset = 1; ram_busy = 1; fl_req = 0; fl_addr = '0; fl_wdata = '0;
        cpu_valid = 0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0; sd_wait = 0;
        cyc(4);
        chk("reset_sd_rd_wr", {30'h0, sd_rd, sd_wr}, 32'h0);
        chk("reset_sd_addr", {9'h0, sd_addr}, 32'h0);
        chk("reset_ds_din", {14'h0, sd_ds, sd_din}, 32'h0);
        chk("reset_acks", {30'h0, fl_ack, cpu_ready}, 32'h0);
        chk("reset_rdata", cpu_rdata, 32'h0);
        reset = 0;

        // ram_busy blocks grants; bit0 of the flash address is dropped
        exp_q.push_back(mk(K_WR, 23'h000104, 32'h0000_ABCD, 2'b11, 1'b0));
        exp_q.push_back(mk(K_WEND, '0, 32'd2, 2'b00, 1'b0));
        exp_q.push_back(mk(K_FLACK, '0, 32'h0, 2'b00, 1'b0));
        fl_req = 1; fl_addr = 23'h000105; fl_wdata = 16'hABCD;
        n = 0;
        repeat (10) begin cyc(1); if (sd_wr) n++; end
        chk("busy_no_grant", n, 0);
        ram_busy = 0;
        wait_sig(0, "busy_fl_ack");
        fl_req = 0;
        cyc(6);

        // flash write 0x1234 @0x102
        to_slot();
        exp_q.push_back(mk(K_WR, 23'h000102, 32'h0000_1234, 2'b11, 1'b0));
        exp_q.push_back(mk(K_WEND, '0, 32'd2, 2'b00, 1'b0));
        exp_q.push_back(mk(K_FLACK, '0, 32'h0, 2'b00, 1'b0));
        fl_req = 1; fl_addr = 23'h000102; fl_wdata = 16'h1234;
        wait_sig(0, "fl_ack");
        fl_req = 0;
        cyc(6);

        // CPU read @0x100 with latency check
        to_slot();
        exp_q.push_back(mk(K_RD, 23'h000100, 32'h0, 2'b11, 1'b0));
        exp_q.push_back(mk(K_RD, 23'h000102, 32'h0, 2'b11, 1'b0));
        exp_q.push_back(mk(K_RDY, '0, 32'hDEAD_BEEF, 2'b00, 1'b1));
        cpu_valid = 1; cpu_addr = 32'h0000_0100; cpu_wstrb = 4'b0000;
        wait_sig(2, "rd_issue");
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1); n++;
            if (cpu_ready) break;
        end
        chk("rd_latency", n, 8);
        cpu_valid = 0;
        cyc(6);

        // posted writes: hi only, full word, lo only
        to_slot();
        exp_q.push_back(mk(K_WR, 23'h000202, 32'h0000_CAFE, 2'b11, 1'b0));
        exp_q.push_back(mk(K_RDY, '0, 32'h0, 2'b00, 1'b0));
        exp_q.push_back(mk(K_WEND, '0, 32'd4, 2'b00, 1'b0));
        cpu_valid = 1; cpu_addr = 32'h0000_0200; cpu_wdata = 32'hCAFE_F00D; cpu_wstrb = 4'b1100;
        wait_sig(1, "wr_hi_ready");
        cpu_valid = 0; cpu_wstrb = 4'b0000;
        cyc(10);

        to_slot();
        exp_q.push_back(mk(K_WR, 23'h000204, 32'h0000_CDEF, 2'b11, 1'b0));
        exp_q.push_back(mk(K_RDY, '0, 32'h0, 2'b00, 1'b0));
        exp_q.push_back(mk(K_WR, 23'h000206, 32'h0000_89AB, 2'b11, 1'b0));
        exp_q.push_back(mk(K_WEND, '0, 32'd6, 2'b00, 1'b0));
        cpu_valid = 1; cpu_addr = 32'h0000_0204; cpu_wdata = 32'h89AB_CDEF; cpu_wstrb = 4'b1111;
        wait_sig(1, "wr_full_ready");
        cpu_valid = 0; cpu_wstrb = 4'b0000;
        cyc(10);

        to_slot();
        exp_q.push_back(mk(K_WR, 23'h000208, 32'h0000_2222, 2'b11, 1'b0));
        exp_q.push_back(mk(K_RDY, '0, 32'h0, 2'b00, 1'b0));
        exp_q.push_back(mk(K_WEND, '0, 32'd4, 2'b00, 1'b0));
        cpu_valid = 1; cpu_addr = 32'h0000_0208; cpu_wdata = 32'h1111_2222; cpu_wstrb = 4'b0011;
        wait_sig(1, "wr_lo_ready");
        cpu_valid = 0; cpu_wstrb = 4'b0000;
        cyc(10);

        // simultaneous flash and CPU: flash first
        to_slot();
        exp_q.push_back(mk(K_WR, 23'h000400, 32'h0000_7777, 2'b11, 1'b0));
        exp_q.push_back(mk(K_WEND, '0, 32'd2, 2'b00, 1'b0));
        exp_q.push_back(mk(K_FLACK, '0, 32'h0, 2'b00, 1'b0));
        exp_q.push_back(mk(K_RD, 23'h000400, 32'h0, 2'b11, 1'b0));
        exp_q.push_back(mk(K_RD, 23'h000402, 32'h0, 2'b11, 1'b0));
        exp_q.push_back(mk(K_RDY, '0, 32'hA5A5_5A5A, 2'b00, 1'b1));
        fl_req = 1; fl_addr = 23'h000400; fl_wdata = 16'h7777;
        cpu_valid = 1; cpu_addr = 32'h0000_0400; cpu_wstrb = 4'b0000;
        wait_sig(0, "both_fl_ack");
        fl_req = 0;
        wait_sig(1, "both_cpu_ready");
        cpu_valid = 0;
        cyc(6);

        // sd_wait for 5 cycles while in CPU_HI
        to_slot();
        exp_q.push_back(mk(K_RD, 23'h000300, 32'h0, 2'b11, 1'b0));
        exp_q.push_back(mk(K_RD, 23'h000302, 32'h0, 2'b11, 1'b0));
        exp_q.push_back(mk(K_RDY, '0, 32'h2222_1111, 2'b00, 1'b1));
        cpu_valid = 1; cpu_addr = 32'h0000_0300; cpu_wstrb = 4'b0000;
        cyc(3);
        sd_wait = 1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("wait_hold", {sd_rd, sd_wr, sd_ds, 5'h0, sd_addr}, {1'b1, 1'b0, 2'b11, 5'h0, 23'h000300});
        end
        sd_wait = 0;
        wait_sig(1, "wait_cpu_ready");
        cpu_valid = 0;
        cyc(6);

        // reset while in CPU_RD2
        to_slot();
        exp_q.push_back(mk(K_RD, 23'h000100, 32'h0, 2'b11, 1'b0));
        exp_q.push_back(mk(K_RD, 23'h000102, 32'h0, 2'b11, 1'b0));
        cpu_valid = 1; cpu_addr = 32'h0000_0100; cpu_wstrb = 4'b0000;
        cyc(7);
        reset = 1; cpu_valid = 0;
        cyc(1);
        chk("midrst_sd_rd_wr", {30'h0, sd_rd, sd_wr}, 32'h0);
        chk("midrst_rdata", cpu_rdata, 32'h0);
        chk("midrst_acks_addr", {7'h0, fl_ack, cpu_ready, sd_addr}, 32'h0);
        cyc(1);
        reset = 0;
        cyc(10);

        // address at RAM_LIMIT is never granted
        to_slot();
        cpu_valid = 1; cpu_addr = 32'h0080_0000; cpu_wstrb = 4'b0000;
        n = 0;
        repeat (20) begin cyc(1); if (sd_rd || cpu_ready) n++; end
        chk("limit_no_grant", n, 0);
        cpu_valid = 0;
        cyc(2);

        // last word below RAM_LIMIT is granted
        to_slot();
        exp_q.push_back(mk(K_RD, 23'h7FFFFC, 32'h0, 2'b11, 1'b0));
        exp_q.push_back(mk(K_RD, 23'h7FFFFE, 32'h0, 2'b11, 1'b0));
        exp_q.push_back(mk(K_RDY, '0, 32'h0000_0000, 2'b00, 1'b1));
        cpu_valid = 1; cpu_addr = 32'h007F_FFFC; cpu_wstrb = 4'b0000;
        wait_sig(1, "limit_below_ready");
        cpu_valid = 0;
        cyc(10);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
